hs32_memory: RTL and testbench

- Pipeline stage 4: sits directly downstream of the execute stage.
- Takes the ALU result (used as address or pass-through data), store data, destination register and memory op.
- Performs at most one load/store on a simple strobe/ack data bus; stalls upstream while the bus is busy.
- Drives the regfile write port for loads and pass-through ops; exports its destination register for hazard detection.

---
 rtl/hs32_memory.sv | 150 +++++++++++++++
 tb/tb_hs32_memory.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hs32_memory.sv
//------------------------------------------------------------------------------
// Module   : hs32_memory
// Brief    : Pipeline memory stage. Performs one strobe/ack bus access per
//            load or store, writes loads and pass-through results back.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module hs32_memory #(
  parameter int TIMEOUT = 255,
  parameter int CW      = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        valid_i,
  output logic        ready_o,
  input  logic [1:0]  op_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] sdata_i,
  input  logic [3:0]  rd_i,
  input  logic        we_i,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_dtw_o,
  input  logic [31:0] mem_dtr_i,
  output logic        mem_rw_o,
  output logic        mem_stb_o,
  input  logic        mem_ack_i,
  output logic [3:0]  wp_addr_o,
  output logic [31:0] wp_data_o,
  output logic        wp_we_o,
  output logic [3:0]  rd4_o,
  output logic        rd4_valid_o,
  output logic        fault_o
);

  localparam logic [1:0] c_idle     = 2'd0;
  localparam logic [1:0] c_bus      = 2'd1;
  localparam logic [1:0] c_wb       = 2'd2;
  localparam logic [1:0] c_op_load  = 2'b01;
  localparam logic [1:0] c_op_store = 2'b10;
  localparam logic [CW-1:0] c_timeout = CW'(TIMEOUT);
  localparam logic [CW-1:0] c_one     = {{(CW-1){1'b0}}, 1'b1};

  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic [31:0]   r_mem_addr;
  logic [31:0]   r_mem_dtw;
  logic          r_rw;
  logic          r_stb;
  logic [3:0]    r_wp_addr;
  logic [31:0]   r_wp_data;
  logic          r_wp_we;
  logic [3:0]    r_rd;
  logic          r_fault;

  logic          w_is_mem;
  logic [CW-1:0] w_cnt_next;
  logic          w_timeout;

  assign w_is_mem = (op_i == c_op_load) || (op_i == c_op_store);

  // Counter saturates at TIMEOUT; with TIMEOUT=0 it never leaves zero and never fires.
  assign w_cnt_next = (r_cnt == c_timeout) ? r_cnt : r_cnt + c_one;
  assign w_timeout  = (TIMEOUT != 0) && (w_cnt_next == c_timeout);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= c_idle;
      r_cnt      <= '0;
      r_mem_addr <= 32'd0;
      r_mem_dtw  <= 32'd0;
      r_rw       <= 1'b0;
      r_stb      <= 1'b0;
      r_wp_addr  <= 4'd0;
      r_wp_data  <= 32'd0;
      r_wp_we    <= 1'b0;
      r_rd       <= 4'd0;
      r_fault    <= 1'b0;
    end else begin
      r_wp_we <= 1'b0;
      r_fault <= 1'b0;
      case (r_state)
        c_idle: begin
          if (valid_i) begin
            if (w_is_mem) begin
              if (addr_i[1:0] != 2'b00) begin
                r_fault <= 1'b1;
              end else begin
                r_state    <= c_bus;
                r_cnt      <= '0;
                r_stb      <= 1'b1;
                r_rw       <= (op_i == c_op_store);
                r_mem_addr <= addr_i;
                r_mem_dtw  <= (op_i == c_op_store) ? sdata_i : 32'd0;
                r_rd       <= rd_i;
              end
            end else begin
              r_wp_we   <= we_i;
              r_wp_addr <= rd_i;
              r_wp_data <= addr_i;
              r_rd      <= rd_i;
            end
          end
        end
        c_bus: begin
          if (mem_ack_i) begin
            r_stb <= 1'b0;
            if (r_rw) begin
              r_state <= c_idle;
            end else begin
              // Writeback registers double as the WB-state capture of read data.
              r_state   <= c_wb;
              r_wp_we   <= 1'b1;
              r_wp_addr <= r_rd;
              r_wp_data <= mem_dtr_i;
            end
          end else begin
            r_cnt <= w_cnt_next;
            if (w_timeout) begin
              r_stb   <= 1'b0;
              r_fault <= 1'b1;
              r_state <= c_idle;
            end
          end
        end
        c_wb: begin
          r_state <= c_idle;
        end
        default: begin
          r_state <= c_idle;
        end
      endcase
    end
  end

  assign ready_o     = (r_state == c_idle);
  assign mem_addr_o  = r_mem_addr;
  assign mem_dtw_o   = r_mem_dtw;
  assign mem_rw_o    = r_rw;
  assign mem_stb_o   = r_stb;
  assign wp_addr_o   = r_wp_addr;
  assign wp_data_o   = r_wp_data;
  assign wp_we_o     = r_wp_we;
  assign rd4_o       = r_rd;
  assign rd4_valid_o = ((r_state == c_bus) && !r_rw) || r_wp_we;
  assign fault_o     = r_fault;

endmodule

`default_nettype wire

// File: tb/tb_hs32_memory.sv
//------------------------------------------------------------------------------
// Module   : tb_hs32_memory
// Brief    : Directed bench for hs32_memory with TIMEOUT=4.
// Revision : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_hs32_memory;

  logic        clk = 1'b0;
  logic        reset;
  logic        valid_i;
  logic        ready_o;
  logic [1:0]  op_i;
  logic [31:0] addr_i;
  logic [31:0] sdata_i;
  logic [3:0]  rd_i;
  logic        we_i;
  logic [31:0] mem_addr_o;
  logic [31:0] mem_dtw_o;
  logic [31:0] mem_dtr_i;
  logic        mem_rw_o;
  logic        mem_stb_o;
  logic        mem_ack_i;
  logic [3:0]  wp_addr_o;
  logic [31:0] wp_data_o;
  logic        wp_we_o;
  logic [3:0]  rd4_o;
  logic        rd4_valid_o;
  logic        fault_o;

  int n_chk = 0;
  int n_err = 0;

  hs32_memory #(.TIMEOUT(4), .CW(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .valid_i    (valid_i),
    .ready_o    (ready_o),
    .op_i       (op_i),
    .addr_i     (addr_i),
    .sdata_i    (sdata_i),
    .rd_i       (rd_i),
    .we_i       (we_i),
    .mem_addr_o (mem_addr_o),
    .mem_dtw_o  (mem_dtw_o),
    .mem_dtr_i  (mem_dtr_i),
    .mem_rw_o   (mem_rw_o),
    .mem_stb_o  (mem_stb_o),
    .mem_ack_i  (mem_ack_i),
    .wp_addr_o  (wp_addr_o),
    .wp_data_o  (wp_data_o),
    .wp_we_o    (wp_we_o),
    .rd4_o      (rd4_o),
    .rd4_valid_o(rd4_valid_o),
    .fault_o    (fault_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] sd, input logic [3:0] rd, input logic we);
    valid_i = v;
    op_i    = op;
    addr_i  = a;
    sdata_i = sd;
    rd_i    = rd;
    we_i    = we;
  endtask

  initial begin
    reset     = 1'b1;
    mem_ack_i = 1'b0;
    mem_dtr_i = 32'd0;
    drive(1'b0, 2'b00, 32'd0, 32'd0, 4'd0, 1'b0);
    tick();
    tick();
    reset = 1'b0;
    chk("rst_ready", 32'(ready_o), 32'd1);
    chk("rst_stb", 32'(mem_stb_o), 32'd0);
    chk("rst_wpwe", 32'(wp_we_o), 32'd0);
    chk("rst_fault", 32'(fault_o), 32'd0);
    chk("rst_rd4v", 32'(rd4_valid_o), 32'd0);

    // Three back-to-back pass ops
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, 2'b00, 32'h11 * i, 32'd0, 4'(i), 1'b1);
      tick();
      chk("pass_we", 32'(wp_we_o), 32'd1);
      chk("pass_addr", 32'(wp_addr_o), 32'(i));
      chk("pass_data", wp_data_o, 32'h11 * i);
      chk("pass_ready", 32'(ready_o), 32'd1);
      chk("pass_rd4v", 32'(rd4_valid_o), 32'd1);
    end
    drive(1'b0, 2'b00, 32'd0, 32'd0, 4'd0, 1'b0);
    tick();
    chk("pass_idle_we", 32'(wp_we_o), 32'd0);
    chk("pass_idle_rd4v", 32'(rd4_valid_o), 32'd0);

    // Reserved op with we_i=0 writes nothing
    drive(1'b1, 2'b11, 32'h77, 32'd0, 4'd6, 1'b0);
    tick();
    drive(1'b0, 2'b00, 32'd0, 32'd0, 4'd0, 1'b0);
    chk("rsv_we", 32'(wp_we_o), 32'd0);
    chk("rsv_stb", 32'(mem_stb_o), 32'd0);

    // Aligned load, ack in first strobe cycle
    drive(1'b1, 2'b01, 32'h100, 32'h5555_5555, 4'd5, 1'b0);
    tick();
    drive(1'b0, 2'b00, 32'd0, 32'd0, 4'd0, 1'b0);
    chk("ld_stb", 32'(mem_stb_o), 32'd1);
    chk("ld_rw", 32'(mem_rw_o), 32'd0);
    chk("ld_addr", mem_addr_o, 32'h100);
    chk("ld_dtw", mem_dtw_o, 32'd0);
    chk("ld_ready1", 32'(ready_o), 32'd0);
    chk("ld_rd4", 32'(rd4_o), 32'd5);
    chk("ld_rd4v", 32'(rd4_valid_o), 32'd1);
    mem_ack_i = 1'b1;
    mem_dtr_i = 32'hDEADBEEF;
    tick();
    mem_ack_i = 1'b0;
    mem_dtr_i = 32'd0;
    chk("ld_stb_off", 32'(mem_stb_o), 32'd0);
    chk("ld_wpwe", 32'(wp_we_o), 32'd1);
    chk("ld_wpaddr", 32'(wp_addr_o), 32'd5);
    chk("ld_wpdata", wp_data_o, 32'hDEADBEEF);
    chk("ld_ready2", 32'(ready_o), 32'd0);
    chk("ld_wb_rd4v", 32'(rd4_valid_o), 32'd1);
    tick();
    chk("ld_ready3", 32'(ready_o), 32'd1);
    chk("ld_wpwe_off", 32'(wp_we_o), 32'd0);

    // Store, ack on 4th strobe cycle (coincides with timeout count: ack wins)
    drive(1'b1, 2'b10, 32'h204, 32'hCAFEF00D, 4'd7, 1'b1);
    tick();
    drive(1'b0, 2'b00, 32'd0, 32'd0, 4'd0, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      chk("st_stb", 32'(mem_stb_o), 32'd1);
      chk("st_rw", 32'(mem_rw_o), 32'd1);
      chk("st_addr", mem_addr_o, 32'h204);
      chk("st_dtw", mem_dtw_o, 32'hCAFEF00D);
      chk("st_wpwe", 32'(wp_we_o), 32'd0);
      chk("st_ready", 32'(ready_o), 32'd0);
      chk("st_rd4v", 32'(rd4_valid_o), 32'd0);
      if (i == 4) mem_ack_i = 1'b1;
      tick();
    end
    mem_ack_i = 1'b0;
    chk("st_done_ready", 32'(ready_o), 32'd1);
    chk("st_done_stb", 32'(mem_stb_o), 32'd0);
    chk("st_done_fault", 32'(fault_o), 32'd0);
    chk("st_done_wpwe", 32'(wp_we_o), 32'd0);

    // Stray ack while idle is ignored
    mem_ack_i = 1'b1;
    mem_dtr_i = 32'h0BAD0BAD;
    tick();
    mem_ack_i = 1'b0;
    chk("stray_wpwe", 32'(wp_we_o), 32'd0);
    chk("stray_ready", 32'(ready_o), 32'd1);

    // Misaligned load
    drive(1'b1, 2'b01, 32'h102, 32'd0, 4'd8, 1'b0);
    tick();
    drive(1'b0, 2'b00, 32'd0, 32'd0, 4'd0, 1'b0);
    chk("mis_fault", 32'(fault_o), 32'd1);
    chk("mis_stb", 32'(mem_stb_o), 32'd0);
    chk("mis_wpwe", 32'(wp_we_o), 32'd0);
    chk("mis_ready", 32'(ready_o), 32'd1);
    tick();
    chk("mis_fault_off", 32'(fault_o), 32'd0);
    chk("mis_stb2", 32'(mem_stb_o), 32'd0);

    // Load with no ack: timeout after 4 strobe cycles
    drive(1'b1, 2'b01, 32'h300, 32'd0, 4'd9, 1'b0);
    tick();
    drive(1'b0, 2'b00, 32'd0, 32'd0, 4'd0, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      chk("to_stb", 32'(mem_stb_o), 32'd1);
      chk("to_fault_low", 32'(fault_o), 32'd0);
      tick();
    end
    chk("to_stb_off", 32'(mem_stb_o), 32'd0);
    chk("to_fault", 32'(fault_o), 32'd1);
    chk("to_wpwe", 32'(wp_we_o), 32'd0);
    chk("to_ready", 32'(ready_o), 32'd1);
    tick();
    chk("to_fault_off", 32'(fault_o), 32'd0);
    chk("to_wpwe2", 32'(wp_we_o), 32'd0);

    // Load acked on the 4th strobe cycle: normal writeback
    drive(1'b1, 2'b01, 32'h304, 32'd0, 4'd10, 1'b0);
    tick();
    drive(1'b0, 2'b00, 32'd0, 32'd0, 4'd0, 1'b0);
    for (int i = 1; i <= 4; i++) begin
      chk("la4_stb", 32'(mem_stb_o), 32'd1);
      if (i == 4) begin
        mem_ack_i = 1'b1;
        mem_dtr_i = 32'h12345678;
      end
      tick();
    end
    mem_ack_i = 1'b0;
    chk("la4_wpwe", 32'(wp_we_o), 32'd1);
    chk("la4_wpaddr", 32'(wp_addr_o), 32'd10);
    chk("la4_wpdata", wp_data_o, 32'h12345678);
    chk("la4_fault", 32'(fault_o), 32'd0);
    tick();
    chk("la4_ready", 32'(ready_o), 32'd1);

    // Reset while strobe is high
    drive(1'b1, 2'b01, 32'h400, 32'd0, 4'd11, 1'b0);
    tick();
    drive(1'b0, 2'b00, 32'd0, 32'd0, 4'd0, 1'b0);
    chk("rb_stb", 32'(mem_stb_o), 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rb_stb_off", 32'(mem_stb_o), 32'd0);
    chk("rb_ready", 32'(ready_o), 32'd1);
    chk("rb_wpwe", 32'(wp_we_o), 32'd0);
    chk("rb_fault", 32'(fault_o), 32'd0);
    drive(1'b1, 2'b00, 32'h55, 32'd0, 4'd3, 1'b1);
    tick();
    drive(1'b0, 2'b00, 32'd0, 32'd0, 4'd0, 1'b0);
    chk("rb_pass_we", 32'(wp_we_o), 32'd1);
    chk("rb_pass_addr", 32'(wp_addr_o), 32'd3);
    chk("rb_pass_data", wp_data_o, 32'h55);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
